// File: rtl/decoder_3to8_reg_pkg.sv
// rtl/decoder_3to8_reg_pkg.sv - shared defaults, state encoding and code-word field helpers
package decoder_3to8_reg_pkg;

    localparam int IDX_W_DEF = 3;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // The active flag sits just above the index field of the code word.
    function automatic int act_pos(input int idx_w);
        return idx_w;
    endfunction

endpackage

// File: rtl/decoder_3to8_reg_onehot_dec.sv
// rtl/decoder_3to8_reg_onehot_dec.sv - combinational index to one-hot with forcing enable
module onehot_dec #(
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0]      idx,
    input  logic                  en,
    output logic [2**IDX_W-1:0]   onehot
);

    localparam int OUT_W = 2**IDX_W;

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot = OUT_W'(1) << idx;
        end
    end

endmodule

// File: rtl/decoder_3to8_reg.sv
// rtl/decoder_3to8_reg.sv - registered 3-to-8 decoder with 2-entry skid buffer and accept counter
module decoder_3to8_reg
    import decoder_3to8_reg_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [IDX_W:0]        S,
    output logic                  S_READY,
    output logic [2**IDX_W-1:0]   D,
    output logic                  D_VALID,
    input  logic                  D_READY,
    output logic [CNT_W-1:0]      CNT
);

    localparam int ACT = act_pos(IDX_W);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] m_idx;
    logic [IDX_W-1:0] m_idx_nxt;
    logic [IDX_W-1:0] k_idx;
    logic [IDX_W-1:0] k_idx_nxt;
    logic             s_ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             consume;

    assign accept  = S[ACT] && s_ready_q;
    assign consume = (state != ST_EMPTY) && D_READY;
    assign D_VALID = (state != ST_EMPTY);
    assign S_READY = s_ready_q;
    assign CNT     = cnt_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_EMPTY;
            m_idx     <= '0;
            k_idx     <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            m_idx     <= m_idx_nxt;
            k_idx     <= k_idx_nxt;
            // Registered ready: low exactly while both slots are occupied.
            s_ready_q <= (state_nxt != ST_TWO);
        end
    end

    always_comb begin
        state_nxt = state;
        m_idx_nxt = m_idx;
        k_idx_nxt = k_idx;
        unique case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_ONE;
                    m_idx_nxt = S[IDX_W-1:0];
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    m_idx_nxt = S[IDX_W-1:0];
                end else if (accept) begin
                    state_nxt = ST_TWO;
                    k_idx_nxt = S[IDX_W-1:0];
                end else if (consume) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (consume) begin
                    state_nxt = ST_ONE;
                    m_idx_nxt = k_idx;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    onehot_dec #(
        .IDX_W (IDX_W)
    ) u_dec (
        .idx    (m_idx),
        .en     (D_VALID),
        .onehot (D)
    );

endmodule
